// File: rtl/pio_apb_bridge.sv
// APB3 completer in front of the PIO control register file.
// Decodes each word address against the PIO register map, issues a single
// write strobe or a timed read, and answers with a registered APB response.
module pio_apb_bridge #(
    parameter int unsigned RD_WAIT = 1  // cycles read_addr is held before data_out is sampled (0..3)
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [8:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [8:0]  write_addr,
    output logic [31:0] data_in,
    output logic        write_en,
    output logic [8:0]  read_addr,
    input  logic [31:0] data_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam logic [1:0] RD_WAIT_CNT = RD_WAIT[1:0];

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [8:0]  write_addr_q, write_addr_d;
    logic [31:0] data_in_q, data_in_d;
    logic        write_en_q, write_en_d;
    logic [8:0]  read_addr_q, read_addr_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;  // doubles as the error flag of the current transfer
    logic        addr_ok;

    // Per-SM writable words; the +0xC offset of each SM block is read-only.
    function automatic logic is_sm_writable(input logic [8:0] a);
        case (a)
            9'h0C8, 9'h0CC, 9'h0D0, 9'h0D8, 9'h0DC,
            9'h0E0, 9'h0E4, 9'h0E8, 9'h0F0, 9'h0F4,
            9'h0F8, 9'h0FC, 9'h100, 9'h108, 9'h10C,
            9'h110, 9'h114, 9'h118, 9'h120, 9'h124: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // The four SM blocks (0x0C8..0x127) and the 0x128..0x140 block are contiguous.
    function automatic logic is_readable(input logic [8:0] a);
        logic hit;
        case (a)
            9'h000, 9'h004, 9'h008, 9'h00C, 9'h030,
            9'h038, 9'h03C, 9'h040, 9'h044: hit = 1'b1;
            default:                         hit = (a >= 9'h0C8) && (a <= 9'h140);
        endcase
        return hit && (a[1:0] == 2'b00);
    endfunction

    function automatic logic is_writable(input logic [8:0] a);
        logic hit;
        case (a)
            9'h000, 9'h008, 9'h030, 9'h038,
            9'h12C, 9'h130, 9'h138, 9'h13C: hit = 1'b1;
            default:                         hit = is_sm_writable(a);
        endcase
        return hit && (a[1:0] == 2'b00);
    endfunction

    // Address check for the transfer presented in the setup phase.
    always_comb begin
        addr_ok = pwrite ? is_writable(paddr) : is_readable(paddr);
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one
        // unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_addr_d = write_addr_q;
        data_in_d    = data_in_q;
        read_addr_d  = read_addr_q;
        write_en_d   = 1'b0;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        prdata_d     = '0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    if (!addr_ok) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (pwrite) begin
                        state_d      = WRITE;
                        write_addr_d = paddr;
                        data_in_d    = pwdata;
                        write_en_d   = 1'b1;
                    end else begin
                        state_d     = READ_WAIT;
                        read_addr_d = paddr;
                        cnt_d       = RD_WAIT_CNT;
                    end
                end
            end
            WRITE: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            READ_WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q == 2'd0) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    prdata_d = data_out;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_addr_q <= '0;
            data_in_q    <= '0;
            write_en_q   <= 1'b0;
            read_addr_q  <= '0;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_addr_q <= write_addr_d;
            data_in_q    <= data_in_d;
            write_en_q   <= write_en_d;
            read_addr_q  <= read_addr_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
        end
    end

    assign prdata     = prdata_q;
    assign pready     = pready_q;
    assign pslverr    = pslverr_q;
    assign write_addr = write_addr_q;
    assign data_in    = data_in_q;
    assign write_en   = write_en_q;
    assign read_addr  = read_addr_q;

endmodule

// File: tb/tb_pio_apb_bridge.sv
// Directed bench for pio_apb_bridge. Three instances share the APB inputs:
// index 0 has RD_WAIT=1 (main), index 1 RD_WAIT=0, index 2 RD_WAIT=3.
// A small register-file model sits behind each instance.
module tb_pio_apb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [8:0]  paddr = '0;
    logic [31:0] pwdata = '0;

    logic [31:0] prdata     [3];
    logic        pready     [3];
    logic        pslverr    [3];
    logic [8:0]  write_addr [3];
    logic [31:0] data_in    [3];
    logic        write_en   [3];
    logic [8:0]  read_addr  [3];
    logic [31:0] data_out   [3];

    logic [31:0] mem [128];

    int checks = 0;
    int errors = 0;

    // Results of the last xfer() call, as seen on instance 0.
    int          r_ready;
    int          r_we_cnt;
    int          r_we_cyc;
    logic [31:0] r_prdata;
    logic        r_slverr;
    logic [8:0]  r_wa;
    logic [31:0] r_wd;
    logic [8:0]  r_ra_t1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pio_apb_bridge #(.RD_WAIT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .psel       (psel),
            .penable    (penable),
            .pwrite     (pwrite),
            .paddr      (paddr),
            .pwdata     (pwdata),
            .prdata     (prdata[g]),
            .pready     (pready[g]),
            .pslverr    (pslverr[g]),
            .write_addr (write_addr[g]),
            .data_in    (data_in[g]),
            .write_en   (write_en[g]),
            .read_addr  (read_addr[g]),
            .data_out   (data_out[g])
        );
        assign data_out[g] = mem[read_addr[g][8:2]];
    end

    // Register-file model: written by instance 0, word 0x044 preset to 0x00200404.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            mem[17] <= 32'h0020_0404;
        end else if (write_en[0]) begin
            mem[write_addr[0][8:2]] <= data_in[0];
        end
    end

    // One APB transfer; cycle c=0 is T0. Returns after the pready cycle,
    // leaving psel high so a following call can start with no bubble.
    task automatic xfer(input logic wr, input logic [8:0] a, input logic [31:0] wd);
        logic done;
        done     = 1'b0;
        r_ready  = -1;
        r_we_cnt = 0;
        r_we_cyc = -1;
        r_prdata = 'x;
        r_slverr = 1'bx;
        r_wa     = 'x;
        r_wd     = 'x;
        r_ra_t1  = 'x;
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        for (int c = 0; c < 12 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1 penable = 1'b1;
            end
            @(negedge clk);
            if (write_en[0]) begin
                r_we_cnt++;
                r_we_cyc = c;
                r_wa     = write_addr[0];
                r_wd     = data_in[0];
            end
            if (c == 1) r_ra_t1 = read_addr[0];
            if (pready[0]) begin
                r_ready  = c;
                r_prdata = prdata[0];
                r_slverr = pslverr[0];
                done     = 1'b1;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (prdata[0] !== 32'h0)     begin errors++; $display("FAIL reset_prdata got %h want 0", prdata[0]); end
        checks++; if (pready[0] !== 1'b0)      begin errors++; $display("FAIL reset_pready got %b want 0", pready[0]); end
        checks++; if (pslverr[0] !== 1'b0)     begin errors++; $display("FAIL reset_pslverr got %b want 0", pslverr[0]); end
        checks++; if (write_en[0] !== 1'b0)    begin errors++; $display("FAIL reset_write_en got %b want 0", write_en[0]); end
        checks++; if (write_addr[0] !== 9'h0)  begin errors++; $display("FAIL reset_write_addr got %h want 0", write_addr[0]); end
        checks++; if (data_in[0] !== 32'h0)    begin errors++; $display("FAIL reset_data_in got %h want 0", data_in[0]); end
        checks++; if (read_addr[0] !== 9'h0)   begin errors++; $display("FAIL reset_read_addr got %h want 0", read_addr[0]); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write();
        xfer(1'b1, 9'h000, 32'h0000_000F);
        idle();
        checks++; if (r_we_cnt !== 1)            begin errors++; $display("FAIL wr_we_count got %0d want 1", r_we_cnt); end
        checks++; if (r_we_cyc !== 1)            begin errors++; $display("FAIL wr_we_cycle got T%0d want T1", r_we_cyc); end
        checks++; if (r_wa !== 9'h000)           begin errors++; $display("FAIL wr_write_addr got %h want 000", r_wa); end
        checks++; if (r_wd !== 32'h0000_000F)    begin errors++; $display("FAIL wr_data_in got %h want 0000000f", r_wd); end
        checks++; if (r_ready !== 2)             begin errors++; $display("FAIL wr_pready_cycle got T%0d want T2", r_ready); end
        checks++; if (r_slverr !== 1'b0)         begin errors++; $display("FAIL wr_pslverr got %b want 0", r_slverr); end
        checks++; if (r_prdata !== 32'h0)        begin errors++; $display("FAIL wr_prdata got %h want 0", r_prdata); end
        @(negedge clk);
        checks++; if (data_in[0] !== 32'h0000_000F) begin errors++; $display("FAIL wr_data_in_held got %h want 0000000f", data_in[0]); end
        checks++; if (pready[0] !== 1'b0)        begin errors++; $display("FAIL wr_pready_after got %b want 0", pready[0]); end
    endtask

    task automatic test_read();
        xfer(1'b0, 9'h044, 32'h0);
        idle();
        checks++; if (r_ra_t1 !== 9'h044)        begin errors++; $display("FAIL rd_read_addr_t1 got %h want 044", r_ra_t1); end
        checks++; if (r_ready !== 3)             begin errors++; $display("FAIL rd_pready_cycle got T%0d want T3", r_ready); end
        checks++; if (r_prdata !== 32'h0020_0404) begin errors++; $display("FAIL rd_prdata got %h want 00200404", r_prdata); end
        checks++; if (r_slverr !== 1'b0)         begin errors++; $display("FAIL rd_pslverr got %b want 0", r_slverr); end
        checks++; if (r_we_cnt !== 0)            begin errors++; $display("FAIL rd_we_count got %0d want 0", r_we_cnt); end
        @(negedge clk);
        checks++; if (prdata[0] !== 32'h0)       begin errors++; $display("FAIL rd_prdata_after got %h want 0", prdata[0]); end
        // Top of the readable map is a valid read returning the model's zero.
        xfer(1'b0, 9'h140, 32'h0);
        idle();
        checks++; if (r_ready !== 3 || r_slverr !== 1'b0) begin errors++; $display("FAIL rd_140 got T%0d err %b want T3 err 0", r_ready, r_slverr); end
    endtask

    task automatic test_errors();
        logic [8:0] ea [5];
        logic       ew [5];
        ea = '{9'h004, 9'h02C, 9'h0C9, 9'h0D4, 9'h144};
        ew = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
        for (int i = 0; i < 5; i++) begin
            xfer(ew[i], ea[i], 32'hDEAD_BEEF);
            idle();
            checks++; if (r_ready !== 1)      begin errors++; $display("FAIL err_%h_pready_cycle got T%0d want T1", ea[i], r_ready); end
            checks++; if (r_slverr !== 1'b1)  begin errors++; $display("FAIL err_%h_pslverr got %b want 1", ea[i], r_slverr); end
            checks++; if (r_we_cnt !== 0)     begin errors++; $display("FAIL err_%h_we_count got %0d want 0", ea[i], r_we_cnt); end
            checks++; if (r_prdata !== 32'h0) begin errors++; $display("FAIL err_%h_prdata got %h want 0", ea[i], r_prdata); end
        end
    endtask

    task automatic test_back_to_back();
        int w_ready;
        int w_we;
        xfer(1'b1, 9'h0D8, 32'hA5A5_1234);
        w_ready = r_ready;
        w_we    = r_we_cnt;
        xfer(1'b0, 9'h0D8, 32'h0);
        idle();
        checks++; if (w_ready !== 2)               begin errors++; $display("FAIL b2b_wr_pready_cycle got T%0d want T2", w_ready); end
        checks++; if (w_we !== 1)                  begin errors++; $display("FAIL b2b_wr_we_count got %0d want 1", w_we); end
        checks++; if (r_ready !== 3)               begin errors++; $display("FAIL b2b_rd_pready_cycle got T%0d want T3", r_ready); end
        checks++; if (r_prdata !== 32'hA5A5_1234)  begin errors++; $display("FAIL b2b_rd_prdata got %h want a5a51234", r_prdata); end
        checks++; if (r_slverr !== 1'b0)           begin errors++; $display("FAIL b2b_rd_pslverr got %b want 0", r_slverr); end
    endtask

    task automatic test_rd_wait();
        int          rc [3];
        logic [31:0] rd [3];
        int          want [3];
        want = '{3, 2, 5};
        for (int g = 0; g < 3; g++) begin rc[g] = -1; rd[g] = 'x; end
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'h044;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1 penable = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (pready[g] && rc[g] < 0) begin
                    rc[g] = c;
                    rd[g] = prdata[g];
                end
            end
        end
        idle();
        for (int g = 0; g < 3; g++) begin
            checks++; if (rc[g] !== want[g])        begin errors++; $display("FAIL rdwait_inst%0d_pready_cycle got T%0d want T%0d", g, rc[g], want[g]); end
            checks++; if (rd[g] !== 32'h0020_0404)  begin errors++; $display("FAIL rdwait_inst%0d_prdata got %h want 00200404", g, rd[g]); end
        end
    endtask

    task automatic test_abort_read();
        int seen;
        seen = 0;
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'h044;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        if (pready[0] || pready[2]) seen++;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (pready[0] || pready[2]) seen++;
        end
        checks++; if (seen !== 0)            begin errors++; $display("FAIL abort_rd_pready_seen got %0d want 0", seen); end
        checks++; if (pslverr[0] !== 1'b0)   begin errors++; $display("FAIL abort_rd_pslverr got %b want 0", pslverr[0]); end
        checks++; if (prdata[0] !== 32'h0)   begin errors++; $display("FAIL abort_rd_prdata got %h want 0", prdata[0]); end
    endtask

    task automatic test_reset_in_write();
        int seen;
        seen = 0;
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h008; pwdata = 32'h0000_0055;
        @(posedge clk);
        #1 penable = 1'b1;
        #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checks++; if (write_en[0] !== 1'b0)   begin errors++; $display("FAIL rstwr_write_en got %b want 0", write_en[0]); end
        checks++; if (write_addr[0] !== 9'h0) begin errors++; $display("FAIL rstwr_write_addr got %h want 0", write_addr[0]); end
        checks++; if (data_in[0] !== 32'h0)   begin errors++; $display("FAIL rstwr_data_in got %h want 0", data_in[0]); end
        checks++; if (read_addr[0] !== 9'h0)  begin errors++; $display("FAIL rstwr_read_addr got %h want 0", read_addr[0]); end
        checks++; if (prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin errors++; $display("FAIL rstwr_prdata_pslverr got %h/%b want 0/0", prdata[0], pslverr[0]); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pready[0]) seen++;
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (pready[0]) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstwr_pready_seen got %0d want 0", seen); end
        xfer(1'b1, 9'h008, 32'h0000_0055);
        checks++; if (r_ready !== 2 || r_we_cnt !== 1) begin errors++; $display("FAIL rstwr_after_wr got T%0d we %0d want T2 we 1", r_ready, r_we_cnt); end
        xfer(1'b0, 9'h008, 32'h0);
        idle();
        checks++; if (r_ready !== 3)              begin errors++; $display("FAIL rstwr_after_rd_cycle got T%0d want T3", r_ready); end
        checks++; if (r_prdata !== 32'h0000_0055) begin errors++; $display("FAIL rstwr_after_rd_prdata got %h want 00000055", r_prdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_back_to_back();
        test_rd_wait();
        test_abort_read();
        test_reset_in_write();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1, "watchdog");
    end

endmodule
